// File: rtl/conv_line_ctrl.sv
// rtl/conv_line_ctrl.sv - four-line rotating buffer and 3x3 window scheduler for the filter datapath
module conv_line_ctrl #(
    parameter int IMG_W = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic        pixel_in_ready,
    output logic [71:0] box_out,
    output logic        box_out_valid,
    output logic        line_done_intr
);

    localparam int FILL_W = $clog2(4*IMG_W+1);
    localparam int CNT_W  = $clog2(IMG_W);

    localparam logic [CNT_W-1:0]  LAST_COL   = CNT_W'(IMG_W-1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4*IMG_W);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3*IMG_W);
    localparam logic [FILL_W-1:0] LINE_PIX   = FILL_W'(IMG_W);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]        line_mem [4][IMG_W];
    logic [CNT_W-1:0]  wr_cnt;
    logic [1:0]        wr_sel;
    logic [CNT_W-1:0]  rd_cnt;
    logic [1:0]        rd_sel;
    logic [FILL_W-1:0] fill;

    logic              wr_en;
    logic              rd_issue;
    logic              line_end;
    logic [1:0]        sel0;
    logic [1:0]        sel1;
    logic [1:0]        sel2;
    logic [CNT_W-1:0]  col_l;
    logic [CNT_W-1:0]  col_r;
    logic [71:0]       window;

    // Fill counts every stored pixel not yet retired by a completed output line;
    // capping it at four lines keeps the writer out of the three lines being read.
    assign pixel_in_ready = (fill < FILL_FULL);
    assign wr_en          = pixel_in_valid && pixel_in_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_sel][wr_cnt] <= pixel_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            wr_sel <= '0;
        end else if (wr_en) begin
            if (wr_cnt == LAST_COL) begin
                wr_cnt <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill <= '0;
        end else begin
            fill <= fill + {{(FILL_W-1){1'b0}}, wr_en} - (line_end ? LINE_PIX : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_issue   = 1'b0;
        line_end   = 1'b0;
        case (state)
            IDLE: begin
                if (fill >= FILL_START) begin
                    state_next = READ;
                end
            end
            READ: begin
                rd_issue = 1'b1;
                if (rd_cnt == LAST_COL) begin
                    line_end   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            rd_sel <= '0;
        end else if (rd_issue) begin
            if (line_end) begin
                rd_cnt <= '0;
                rd_sel <= rd_sel + 2'd1;
            end else begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    // Edge columns replicate the border pixel instead of reading outside the line.
    assign sel0  = rd_sel;
    assign sel1  = rd_sel + 2'd1;
    assign sel2  = rd_sel + 2'd2;
    assign col_l = (rd_cnt == '0) ? rd_cnt : rd_cnt - CNT_W'(1);
    assign col_r = (rd_cnt == LAST_COL) ? rd_cnt : rd_cnt + CNT_W'(1);

    assign window = {line_mem[sel2][col_r], line_mem[sel2][rd_cnt], line_mem[sel2][col_l],
                     line_mem[sel1][col_r], line_mem[sel1][rd_cnt], line_mem[sel1][col_l],
                     line_mem[sel0][col_r], line_mem[sel0][rd_cnt], line_mem[sel0][col_l]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_out        <= '0;
            box_out_valid  <= 1'b0;
            line_done_intr <= 1'b0;
        end else begin
            box_out_valid  <= rd_issue;
            line_done_intr <= line_end;
            if (rd_issue) begin
                box_out <= window;
            end
        end
    end

endmodule
